// File: rtl/csr_pkg.sv
// Shared constants for the CSR automaton memory: line geometry and default capacity.
package csr_pkg;
    localparam int ADDR_W             = 20;
    localparam int LINE_W             = 512;
    localparam int SIZE_RANGE_DEFAULT = 33432;
endpackage

// File: rtl/csr_line_packer.sv
// Assembles WORD_W stream words into one LINE_W line, word 0 in the LSBs.
module csr_line_packer
    import csr_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [WORD_W-1:0] data,
    output logic [LINE_W-1:0] line_next,
    output logic              line_full
);
    localparam int LANES  = LINE_W / WORD_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANE_W-1:0] lane;
    logic [LINE_W-1:0] line_q;

    // line_next already contains the incoming word so the top can capture a full line on the last transfer.
    always_comb begin
        line_next = line_q;
        line_next[int'(lane)*WORD_W +: WORD_W] = data;
    end

    assign line_full = load && (lane == LANE_W'(LANES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane   <= '0;
            line_q <= '0;
        end else if (clear) begin
            lane <= '0;
        end else if (load) begin
            line_q <= line_next;
            lane   <= line_full ? '0 : lane + LANE_W'(1);
        end
    end
endmodule

// File: rtl/csr_bram_loader.sv
// Loads line_count 512-bit CSR lines from a word stream into the automaton BRAM write port.
module csr_bram_loader
    import csr_pkg::*;
#(
    parameter int SIZE_RANGE = SIZE_RANGE_DEFAULT,
    parameter int WORD_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] line_count,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [LINE_W-1:0] bram_din,
    output logic              bram_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] lines_written,
    output logic [1:0]        state_dbg
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] MAX_LINES = ADDR_W'(SIZE_RANGE);

    state_t            state, state_next;
    logic [ADDR_W-1:0] line_idx;
    logic [ADDR_W-1:0] count_q;
    logic              start_ok;
    logic              xfer;
    logic              line_full;
    logic              last_line;
    logic [LINE_W-1:0] line_next;

    // Handshake: a word moves on a rising edge where s_valid and s_ready are both 1; s_ready depends only on state.
    assign s_ready   = (state == COLLECT);
    assign bram_we   = (state == WRITE);
    assign busy      = (state == COLLECT) || (state == WRITE);
    assign done      = (state == DONE);
    assign state_dbg = state;
    assign xfer      = s_valid && s_ready;
    assign start_ok  = start && (line_count != '0) && (line_count <= MAX_LINES);
    assign last_line = (line_idx == count_q - ADDR_W'(1));

    csr_line_packer #(.WORD_W(WORD_W)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     ((state == IDLE) && start_ok),
        .load      (xfer),
        .data      (s_data),
        .line_next (line_next),
        .line_full (line_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = COLLECT;
            COLLECT: if (line_full) state_next = WRITE;
            WRITE:   state_next = last_line ? DONE : COLLECT;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_idx      <= '0;
            count_q       <= '0;
            lines_written <= '0;
            bram_addr     <= '0;
            bram_din      <= '0;
            err           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        err           <= 1'b0;
                        lines_written <= '0;
                        line_idx      <= '0;
                        count_q       <= line_count;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                // Capture address and data on the last transfer so WRITE follows it by exactly one cycle.
                COLLECT: begin
                    if (line_full) begin
                        bram_din  <= line_next;
                        bram_addr <= line_idx;
                    end
                end
                WRITE: begin
                    lines_written <= lines_written + ADDR_W'(1);
                    if (!last_line) line_idx <= line_idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_csr_bram_loader.sv
// Directed bench for csr_bram_loader: a scoreboard queue of expected line writes checked by a write monitor.
module tb_csr_bram_loader;
    import csr_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] line_count = '0;
    logic [31:0]       s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [ADDR_W-1:0] bram_addr;
    logic [LINE_W-1:0] bram_din;
    logic              bram_we;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] lines_written;
    logic [1:0]        state_dbg;

    csr_bram_loader dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .line_count    (line_count),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .bram_addr     (bram_addr),
        .bram_din      (bram_din),
        .bram_we       (bram_we),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .lines_written (lines_written),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int we_count = 0;
    int last_we_cycle = -100;
    int we_cycles[$];
    logic [LINE_W-1:0] last_din = '0;
    logic [ADDR_W+LINE_W-1:0] exp_q[$];

    always @(posedge clk) cycle = cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [LINE_W-1:0] make_line(input logic [31:0] base);
        logic [LINE_W-1:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic push_exp(input logic [ADDR_W-1:0] addr, input logic [31:0] base);
        exp_q.push_back({addr, make_line(base)});
    endtask

    // Write monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            logic [ADDR_W+LINE_W-1:0] e;
            we_count = we_count + 1;
            last_we_cycle = cycle;
            we_cycles.push_back(cycle);
            last_din = bram_din;
            check("s_ready_in_write", 64'(s_ready), 64'd0);
            if (exp_q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_write: addr %0h, no write expected", bram_addr);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 64'(bram_addr), 64'(e[ADDR_W+LINE_W-1:LINE_W]));
                checks = checks + 1;
                if (bram_din !== e[LINE_W-1:0]) begin
                    errors = errors + 1;
                    $display("FAIL write_din: addr %0h got %0h expected %0h",
                             bram_addr, bram_din[63:0], e[63:0]);
                end
            end
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] n);
        @(negedge clk);
        start = 1'b1;
        line_count = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_words(input logic [31:0] base, input int first, input int last, input int max_gap);
        for (int k = first; k <= last; k++) begin
            int to;
            if (max_gap > 0) begin
                int g;
                g = $urandom_range(0, max_gap);
                for (int j = 0; j < g; j++) @(negedge clk);
            end
            s_data = base + 32'(k);
            s_valid = 1'b1;
            to = 0;
            while (s_ready !== 1'b1 && to < 50) begin
                @(negedge clk);
                to = to + 1;
            end
            if (to >= 50) check("s_ready_timeout", 64'(s_ready), 64'd1);
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output int gap);
        int to;
        to = 0;
        while (done !== 1'b1 && to < 100) begin
            @(negedge clk);
            to = to + 1;
        end
        check("done_seen", 64'(done), 64'd1);
        gap = cycle - last_we_cycle;
    endtask

    initial begin
        int gap;
        int wc;

        repeat (3) @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_bram_we", 64'(bram_we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_lines_written", 64'(lines_written), 64'd0);
        check("rst_bram_din", 64'(bram_din[63:0]), 64'd0);
        reset = 1'b1;

        // Single line, words 0..F.
        push_exp(20'd0, 32'h0);
        do_start(20'd1);
        check("t1_busy", 64'(busy), 64'd1);
        send_words(32'h0, 0, 15, 0);
        wait_done(gap);
        check("t1_done_after_write", 64'(gap), 64'd1);
        check("t1_busy_in_done", 64'(busy), 64'd0);
        check("t1_din_lo", 64'(last_din[31:0]), 64'h0);
        check("t1_din_hi", 64'(last_din[511:480]), 64'hF);
        @(negedge clk);
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_lines_written", 64'(lines_written), 64'd1);

        // Three gap-free lines, writes 17 cycles apart.
        we_cycles.delete();
        push_exp(20'd0, 32'h1000);
        push_exp(20'd1, 32'h1100);
        push_exp(20'd2, 32'h1200);
        do_start(20'd3);
        send_words(32'h1000, 0, 15, 0);
        send_words(32'h1100, 0, 15, 0);
        send_words(32'h1200, 0, 15, 0);
        wait_done(gap);
        check("t2_write_count", 64'(we_cycles.size()), 64'd3);
        if (we_cycles.size() == 3) begin
            check("t2_spacing_a", 64'(we_cycles[1] - we_cycles[0]), 64'd17);
            check("t2_spacing_b", 64'(we_cycles[2] - we_cycles[1]), 64'd17);
        end
        check("t2_lines_written", 64'(lines_written), 64'd3);

        // Illegal counts set err and leave the block idle.
        wc = we_count;
        do_start(20'd0);
        check("t3_err_zero", 64'(err), 64'd1);
        check("t3_busy_zero", 64'(busy), 64'd0);
        do_start(20'd33433);
        check("t3_err_big", 64'(err), 64'd1);
        check("t3_busy_big", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("t3_no_write", 64'(we_count), 64'(wc));

        // Random stalls over two lines; same data as the gap-free case.
        push_exp(20'd0, 32'h1000);
        push_exp(20'd1, 32'h1100);
        do_start(20'd2);
        check("t4_err_cleared", 64'(err), 64'd0);
        send_words(32'h1000, 0, 15, 3);
        send_words(32'h1100, 0, 15, 3);
        wait_done(gap);
        check("t4_lines_written", 64'(lines_written), 64'd2);

        // Reset after the 7th word of line 1.
        push_exp(20'd0, 32'h2000);
        do_start(20'd2);
        send_words(32'h2000, 0, 15, 0);
        send_words(32'h2100, 0, 6, 0);
        wc = we_count;
        reset = 1'b0;
        #1;
        check("t5_s_ready", 64'(s_ready), 64'd0);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_lines_written", 64'(lines_written), 64'd0);
        check("t5_bram_addr", 64'(bram_addr), 64'd0);
        check("t5_bram_din", 64'(bram_din[511:448]), 64'd0);
        check("t5_state", 64'(state_dbg), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_no_write", 64'(we_count), 64'(wc));
        check("t5_idle_after", 64'(busy), 64'd0);
        push_exp(20'd0, 32'h3000);
        do_start(20'd1);
        send_words(32'h3000, 0, 15, 0);
        wait_done(gap);

        // Start pulse mid-session is ignored.
        wc = we_count;
        push_exp(20'd0, 32'h4000);
        push_exp(20'd1, 32'h4100);
        do_start(20'd2);
        send_words(32'h4000, 0, 3, 0);
        start = 1'b1;
        line_count = 20'd5;
        @(negedge clk);
        start = 1'b0;
        send_words(32'h4000, 4, 15, 0);
        send_words(32'h4100, 0, 15, 0);
        wait_done(gap);
        check("t6_lines_written", 64'(lines_written), 64'd2);
        repeat (20) @(negedge clk);
        check("t6_write_count", 64'(we_count - wc), 64'd2);
        check("t6_idle", 64'(busy), 64'd0);

        check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/csr_bram_loader.md
CSR_BRAM_LOADER -- requirements
Module: csr_bram_loader

Interface
REQ-001 Parameter SIZE_RANGE, default 33432, is the maximum number of 512-bit CSR lines the automaton memory holds.
REQ-002 Parameter WORD_W, default 32, is the input stream word width; it SHALL divide 512 (LANES = 512/WORD_W, 16 at default).
REQ-003 clk  input  1  sole clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 line_count  input  20  number of lines to load; sampled on an accepted start.
REQ-007 s_data  input  WORD_W  stream word.
REQ-008 s_valid  input  1  s_data is valid.
REQ-009 s_ready  output  1  loader accepts s_data; transfer occurs when s_valid and s_ready are both 1.
REQ-010 bram_addr  output  20  line address on the memory write port.
REQ-011 bram_din  output  512  line write data.
REQ-012 bram_we  output  1  write strobe; one cycle per line.
REQ-013 busy  output  1  a session is in progress.
REQ-014 done  output  1  one-cycle pulse when the last line is written.
REQ-015 err  output  1  sticky parameter error; cleared by the next accepted start.
REQ-016 lines_written  output  20  count of lines written in the current or last session.

Function
REQ-017 The block SHALL have the states IDLE, COLLECT, WRITE and DONE.
REQ-018 IDLE: s_ready=0, bram_we=0; start with 1<=line_count<=SIZE_RANGE -> COLLECT, err=0, lines_written=0, lane=0, line index=0.
REQ-019 IDLE: start with line_count==0 or line_count>SIZE_RANGE -> err=1, remain IDLE, busy stays 0.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 COLLECT: s_ready=1; each transfer SHALL write s_data into lane bits [lane*WORD_W +: WORD_W] (word 0 = LSBs), then increment lane.
REQ-022 A transfer on lane LANES-1 SHALL move to WRITE on the next edge; lane wraps to 0.
REQ-023 WRITE: one cycle, bram_we=1, bram_addr=line index, bram_din=assembled line, s_ready=0; latency from the last-word transfer to bram_we is exactly 1 cycle.
REQ-024 WRITE exit: lines_written increments; if the line index equals line_count-1 -> DONE, else the line index increments and the state returns to COLLECT.
REQ-025 DONE: done=1 for one cycle, s_ready=0, then IDLE; busy SHALL be 1 in COLLECT and WRITE and 0 in DONE and IDLE.
REQ-026 Stalls (s_valid=0) in COLLECT SHALL hold all state; there is no timeout.
REQ-027 bram_addr and bram_din SHALL hold their last values outside WRITE; bram_we SHALL be 0 outside WRITE.

Reset
REQ-028 When reset=0, the block SHALL asynchronously force IDLE, lane=0, line index=0, lines_written=0, bram_addr=0, bram_din=0, bram_we=0, s_ready=0, busy=0, done=0 and err=0.
REQ-029 Reset during a session SHALL discard the partial line and issue no write; after reset deasserts, a new start is required.

Structure
REQ-030 The shared package csr_pkg SHALL hold ADDR_W=20, LINE_W=512 and the SIZE_RANGE default shared with the traversal engine.
REQ-031 The state enumeration SHALL be local to the module.
REQ-032 One sub-module, csr_line_packer, SHALL hold the lane counter and the 512-bit assembly register, with a line_full output.

Verification
REQ-033 Load of 1 line with words 0x0..0xF: bram_we is pulsed once at addr 0 with din[31:0]=0, din[511:480]=0xF, and done is asserted in the cycle after the write.
REQ-034 line_count=3 with gap-free s_valid: there are exactly 3 writes at addr 0,1,2, each 17 cycles apart, and lines_written ends at 3.
REQ-035 line_count=0 and, separately, line_count=33433: err=1, busy stays 0, no write occurs; a following valid start clears err.
REQ-036 s_valid toggled randomly over 2 lines: data is identical to the gap-free case and s_ready=0 in every WRITE cycle.
REQ-037 reset=0 asserted after the 7th word of line 1: no bram_we is issued, all outputs are 0, and a new start reloads from addr 0.
REQ-038 start pulsed mid-session with line_count=5: the pulse is ignored and the original count completes.
